// File: rtl/ibex_register_file_two_level.sv
// ibex_register_file_two_level: L1 flop window + latent L2 array with posted write buffer
module ibex_register_file_two_level #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned L1Base    = 8,
    parameter int unsigned L1Size    = 8,
    parameter int unsigned L2Latency = 2,
    parameter int unsigned WbDepth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_new_i,
    input  logic                 ren_a_i,
    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic                 ren_b_i,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic                 we_a_i,
    input  logic [4:0]           waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    output logic                 stall_o,
    output logic [31:0]          l2_miss_o
);
    localparam int unsigned AW      = RV32E ? 4 : 5;
    localparam int unsigned NumRegs = 2 ** AW;
    localparam int unsigned IW      = L1Size > 1 ? $clog2(L1Size) : 1;
    localparam int unsigned PW      = $clog2(WbDepth);
    localparam int unsigned CntW    = $clog2(WbDepth + 1);
    localparam logic [AW:0] L1Lo    = (AW + 1)'(L1Base);
    localparam logic [AW:0] L1Hi    = (AW + 1)'(L1Base + L1Size);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B} state_e;

    state_e                state_q, state_d;
    logic [1:0]            lat_q;
    logic [DataWidth-1:0]  l1_q [L1Size];
    logic [DataWidth-1:0]  l2_q [NumRegs];
    logic [AW-1:0]         wb_addr_q [WbDepth];
    logic [DataWidth-1:0]  wb_data_q [WbDepth];
    logic [CntW-1:0]       wb_cnt_q;
    logic                  valid_a_q, valid_b_q;
    logic [DataWidth-1:0]  buf_a_q, buf_b_q;
    logic [AW-1:0]         ea_a, ea_b, ew;
    logic [DataWidth:0]    lk_a, lk_b;
    logic                  va, vb, miss_a, miss_b, last, cap_a, cap_b, enter;
    logic                  wr_l1, wr_l2, pop, push, wr_buf_a, wr_buf_b;
    logic [PW-1:0]         push_idx;

    function automatic logic is_l1(input logic [AW-1:0] a);
        return {1'b0, a} >= L1Lo && {1'b0, a} < L1Hi;
    endfunction

    function automatic logic [IW-1:0] l1_idx(input logic [AW-1:0] a);
        return IW'(a - L1Lo[AW-1:0]);
    endfunction

    // Zero-latency sources: x0, L1 window, newest matching WB entry; MSB flags a hit
    function automatic logic [DataWidth:0] lookup(input logic [AW-1:0] a);
        logic [DataWidth:0] r;
        r = '0;
        if (a == '0) r = {1'b1, {DataWidth{1'b0}}};
        else if (is_l1(a)) r = {1'b1, l1_q[l1_idx(a)]};
        else
            for (int i = 0; i < WbDepth; i++)
                if (CntW'(i) < wb_cnt_q && wb_addr_q[i] == a) r = {1'b1, wb_data_q[i]};
        return r;
    endfunction

    assign ea_a      = raddr_a_i[AW-1:0];
    assign ea_b      = raddr_b_i[AW-1:0];
    assign ew        = waddr_a_i[AW-1:0];
    assign lk_a      = lookup(ea_a);
    assign lk_b      = lookup(ea_b);
    assign va        = valid_a_q & ~instr_new_i;
    assign vb        = valid_b_q & ~instr_new_i;
    assign miss_a    = ren_a_i & ~lk_a[DataWidth] & ~va;
    assign miss_b    = ren_b_i & ~lk_b[DataWidth] & ~vb;
    assign rdata_a_o = va ? buf_a_q : lk_a[DataWidth-1:0];
    assign rdata_b_o = vb ? buf_b_q : lk_b[DataWidth-1:0];
    assign last      = lat_q == 2'(L2Latency - 1);
    assign wr_l1     = we_a_i & is_l1(ew);
    assign wr_l2     = we_a_i & (ew != '0) & ~is_l1(ew);
    assign pop       = (wb_cnt_q != '0) & (state_q == IDLE) & ~miss_a & ~miss_b;
    assign push      = wr_l2 & ((wb_cnt_q < CntW'(WbDepth)) | pop);
    assign push_idx  = PW'(wb_cnt_q - CntW'(pop));
    assign wr_buf_a  = we_a_i & (ew != '0) & (ew == ea_a) & (cap_a | valid_a_q);
    assign wr_buf_b  = we_a_i & (ew != '0) & (ew == ea_b) & (cap_b | valid_b_q);

    // FSM state, L2 latency counter and saturating L2 access counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            l2_miss_o <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= (state_q == IDLE || last) ? '0 : lat_q + 2'd1;
            if (enter && l2_miss_o != '1) l2_miss_o <= l2_miss_o + 32'd1;
        end
    end

    // Next state: serve A first, then B if it still misses after A completes
    always_comb begin
        state_d = (state_q == IDLE) ? (miss_a ? RD_A : miss_b ? RD_B : IDLE)
                : !last ? state_q
                : (state_q == RD_A && miss_b) ? RD_B : IDLE;
    end

    // FSM outputs: capture strobes, L2 access count event and ID stall
    always_comb begin
        cap_a   = (state_q == RD_A) & last;
        cap_b   = (state_q == RD_B) & last;
        enter   = (state_d != IDLE) & (state_d != state_q);
        stall_o = miss_a | miss_b | (state_q != IDLE) | (wb_cnt_q >= CntW'(WbDepth - 1));
    end

    // Storage: L1 writes, WB push/drain into L2, operand buffer capture and update
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < L1Size; i++) l1_q[i] <= '0;
            for (int i = 0; i < NumRegs; i++) l2_q[i] <= '0;
            for (int i = 0; i < WbDepth; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
            wb_cnt_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            buf_a_q   <= '0;
            buf_b_q   <= '0;
        end else begin
            if (wr_l1) l1_q[l1_idx(ew)] <= wdata_a_i;
            if (pop) begin
                l2_q[wb_addr_q[0]] <= wb_data_q[0];
                for (int i = 0; i < WbDepth - 1; i++) begin
                    wb_addr_q[i] <= wb_addr_q[i+1];
                    wb_data_q[i] <= wb_data_q[i+1];
                end
            end
            if (push) begin
                wb_addr_q[push_idx] <= ew;
                wb_data_q[push_idx] <= wdata_a_i;
            end
            wb_cnt_q  <= wb_cnt_q + CntW'(push) - CntW'(pop);
            valid_a_q <= (valid_a_q & ~instr_new_i) | cap_a;
            valid_b_q <= (valid_b_q & ~instr_new_i) | cap_b;
            if (cap_a) buf_a_q <= lk_a[DataWidth] ? lk_a[DataWidth-1:0] : l2_q[ea_a];
            if (cap_b) buf_b_q <= lk_b[DataWidth] ? lk_b[DataWidth-1:0] : l2_q[ea_b];
            if (wr_buf_a) buf_a_q <= wdata_a_i;
            if (wr_buf_b) buf_b_q <= wdata_a_i;
        end
    end
endmodule

// File: tb/tb_ibex_register_file_two_level.sv
// tb_ibex_register_file_two_level: directed scoreboard bench for the two-level register file
module tb_ibex_register_file_two_level;
    logic        clk_i = 1'b0;
    logic        rst_ni, instr_new_i, ren_a_i, ren_b_i, we_a_i, stall_o;
    logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
    logic [31:0] rdata_a_o, rdata_b_o, wdata_a_i, l2_miss_o;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   errors = 0;
    int   checks = 0;

    ibex_register_file_two_level dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .instr_new_i(instr_new_i),
        .ren_a_i(ren_a_i), .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
        .ren_b_i(ren_b_i), .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
        .we_a_i(we_a_i), .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i),
        .stall_o(stall_o), .l2_miss_o(l2_miss_o)
    );

    always #5 clk_i = ~clk_i;

    // sel: 0 stall_o, 1 rdata_a_o, 2 rdata_b_o, 3 l2_miss_o
    task automatic chk(input string n, input int s, input logic [31:0] e);
        q.push_back('{n, s, e});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: checks every expectation queued for this cycle at the falling edge
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk_i);
            while (q.size() != 0) begin
                c = q.pop_front();
                act = c.sel == 0 ? {31'b0, stall_o} : c.sel == 1 ? rdata_a_o :
                      c.sel == 2 ? rdata_b_o : l2_miss_o;
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic single(input logic [4:0] a, input logic [31:0] ea, input logic [31:0] em);
        step();
        instr_new_i = 1; ren_a_i = 1; raddr_a_i = a; ren_b_i = 0; we_a_i = 0;
        chk("single_stall0", 0, 1);
        for (int i = 1; i <= 2; i++) begin
            step();
            instr_new_i = 0;
            chk("single_stall", 0, 1);
        end
        step();
        chk("single_done", 0, 0);
        chk("single_rdata_a", 1, ea);
        chk("single_l2miss", 3, em);
    endtask

    task automatic pair(input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] em);
        step();
        instr_new_i = 1; ren_a_i = 1; raddr_a_i = a; ren_b_i = 1; raddr_b_i = b; we_a_i = 0;
        chk("pair_stall0", 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            instr_new_i = 0;
            chk("pair_stall", 0, 1);
            if (i == 3) chk("pair_bufa_mid", 1, ea);
        end
        step();
        chk("pair_done", 0, 0);
        chk("pair_rdata_a", 1, ea);
        chk("pair_rdata_b", 2, eb);
        chk("pair_l2miss", 3, em);
    endtask

    initial begin
        rst_ni = 0; instr_new_i = 0; ren_a_i = 0; raddr_a_i = 0; ren_b_i = 0; raddr_b_i = 0;
        we_a_i = 0; waddr_a_i = 0; wdata_a_i = 0;
        repeat (2) step();
        rst_ni = 1; ren_a_i = 1; raddr_a_i = 9;
        chk("reset_stall", 0, 0);
        chk("reset_l2miss", 3, 0);
        chk("reset_rdata_a", 1, 0);
        // L1 write, no same-cycle bypass, x0 ignores writes
        step();
        we_a_i = 1; waddr_a_i = 9; wdata_a_i = 32'hA5A5_0001; instr_new_i = 1;
        chk("no_bypass", 1, 0);
        chk("l1_wr_stall", 0, 0);
        step();
        waddr_a_i = 0; wdata_a_i = 32'hFF;
        chk("l1_read", 1, 32'hA5A5_0001);
        chk("l1_rd_stall", 0, 0);
        step();
        we_a_i = 0; instr_new_i = 0; raddr_a_i = 0;
        chk("x0_read", 1, 0);
        chk("x0_stall", 0, 0);
        // Drained single miss
        step();
        ren_a_i = 0; we_a_i = 1; waddr_a_i = 20; wdata_a_i = 32'h1234;
        chk("wb_push_stall", 0, 0);
        step();
        we_a_i = 0;
        repeat (2) step();
        single(20, 32'h1234, 1);
        // Drained double miss
        step();
        ren_a_i = 0; ren_b_i = 0; instr_new_i = 0; we_a_i = 1; waddr_a_i = 3; wdata_a_i = 7;
        step();
        waddr_a_i = 4; wdata_a_i = 9;
        step();
        we_a_i = 0;
        repeat (2) step();
        pair(3, 4, 7, 9, 3);
        // WB hit right after write
        step();
        ren_a_i = 0; ren_b_i = 0; instr_new_i = 0; we_a_i = 1; waddr_a_i = 5; wdata_a_i = 32'h55;
        chk("wb_hit_wr_stall", 0, 0);
        step();
        we_a_i = 0; instr_new_i = 1; ren_a_i = 1; raddr_a_i = 5;
        chk("wb_hit_rdata", 1, 32'h55);
        chk("wb_hit_stall", 0, 0);
        chk("wb_hit_l2miss", 3, 3);
        step();
        instr_new_i = 0; ren_a_i = 0;
        chk("wb_idle_stall", 0, 0);
        // Fill WB during an A+B miss
        step();
        instr_new_i = 1; ren_a_i = 1; raddr_a_i = 20; ren_b_i = 1; raddr_b_i = 4;
        we_a_i = 1; waddr_a_i = 21; wdata_a_i = 32'h21;
        chk("fill_c0_stall", 0, 1);
        step();
        instr_new_i = 0; waddr_a_i = 22; wdata_a_i = 32'h22;
        chk("fill_c1_stall", 0, 1);
        chk("fill_c1_l2miss", 3, 4);
        step();
        waddr_a_i = 23; wdata_a_i = 32'h23;
        chk("fill_c2_stall", 0, 1);
        step();
        waddr_a_i = 21; wdata_a_i = 32'h2121;
        chk("fill_c3_stall", 0, 1);
        chk("fill_c3_l2miss", 3, 5);
        step();
        we_a_i = 0;
        chk("fill_c4_stall", 0, 1);
        chk("fill_c4_bufa", 1, 32'h1234);
        step();
        instr_new_i = 1; ren_a_i = 1; raddr_a_i = 21; ren_b_i = 0;
        chk("full_wb_stall", 0, 1);
        chk("wb_newest_wins", 1, 32'h2121);
        chk("full_l2miss", 3, 5);
        step();
        instr_new_i = 0; ren_a_i = 0;
        chk("drain_cnt3_stall", 0, 1);
        step();
        chk("drain_cnt2_stall", 0, 0);
        step();
        chk("drain_cnt1_stall", 0, 0);
        pair(21, 22, 32'h2121, 32'h22, 7);
        // Write into a buffered operand
        step();
        we_a_i = 1; waddr_a_i = 21; wdata_a_i = 32'h77;
        chk("bufwr_old", 1, 32'h2121);
        chk("bufwr_stall", 0, 0);
        step();
        we_a_i = 0;
        chk("bufwr_new", 1, 32'h77);
        chk("bufwr_stall2", 0, 0);
        pair(23, 5, 32'h23, 32'h55, 9);
        // Reset in the second RD_A cycle
        step();
        instr_new_i = 1; ren_a_i = 1; raddr_a_i = 20; ren_b_i = 0;
        chk("rst_c0_stall", 0, 1);
        step();
        instr_new_i = 0;
        chk("rst_c1_stall", 0, 1);
        step();
        rst_ni = 0; ren_a_i = 0; raddr_a_i = 9;
        chk("rst_c2_stall", 0, 1);
        step();
        rst_ni = 1;
        chk("post_rst_stall", 0, 0);
        chk("post_rst_l2miss", 3, 0);
        chk("post_rst_l1", 1, 0);
        single(3, 0, 1);
        step();
        @(negedge clk_i);
        #1;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL leftover: got %0d unchecked expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
